// File: rtl/apb_lin_initiator_if.sv
// Command/response and APB requester signals of the APB initiator, grouped for port binding.
// master is the initiator's view; slave is the view of whatever drives commands and models the completer.
interface apb_lin_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
    input  prdata_i, pready_i, pslverr_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
    output prdata_i, pready_i, pslverr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_lin_initiator.sv
// Single-outstanding APB requester: one command in, one response out; 3 cycles accept-to-response at zero wait.
// Accepts commands only in IDLE; the response is held until rsp_ready_i, stalling new commands meanwhile.
module apb_lin_initiator #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 pclk,
  input logic                 preset_i,
  apb_lin_initiator_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The count holds completed wait cycles, so the last permitted ACCESS cycle sees LIMIT.
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  r_write;
  logic                  w_write_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  r_timeout;
  logic                  w_timeout_nxt;

  always_ff @(posedge pclk) begin
    if (!preset_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_write   <= w_write_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_write_nxt   = r_write;
    w_cnt_nxt     = r_cnt;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;
    w_timeout_nxt = r_timeout;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          if (bus.cmd_addr_i[1:0] == 2'b00) begin
            w_state_nxt = S_SETUP;
            w_addr_nxt  = bus.cmd_addr_i;
            w_write_nxt = bus.cmd_write_i;
            // Reads carry zero write data so pwdata_o stays quiet on the bus.
            w_wdata_nxt = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
          end else begin
            w_state_nxt   = S_RESP;
            w_rdata_nxt   = '0;
            w_err_nxt     = 1'b1;
            w_timeout_nxt = 1'b0;
          end
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_cnt_nxt   = '0;
      end
      S_ACCESS: begin
        // A completer answer on the limit cycle takes priority over the timeout.
        if (bus.pready_i) begin
          w_state_nxt   = S_RESP;
          w_err_nxt     = bus.pslverr_i;
          w_timeout_nxt = 1'b0;
          w_rdata_nxt   = r_write ? '0 : bus.prdata_i;
        end else if ((TIMEOUT_CYCLES > 0) && (r_cnt == LIMIT)) begin
          w_state_nxt   = S_RESP;
          w_err_nxt     = 1'b1;
          w_timeout_nxt = 1'b1;
          w_rdata_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Gated by reset so the handshake reads low while reset is held.
  assign bus.cmd_ready_o   = (r_state == S_IDLE) && preset_i;
  assign bus.rsp_valid_o   = (r_state == S_RESP);
  assign bus.rsp_rdata_o   = r_rdata;
  assign bus.rsp_err_o     = r_err;
  assign bus.rsp_timeout_o = r_timeout;
  assign bus.psel_o        = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign bus.penable_o     = (r_state == S_ACCESS);
  assign bus.pwrite_o      = r_write;
  assign bus.paddr_o       = r_addr;
  assign bus.pwdata_o      = r_wdata;

endmodule

// File: tb/tb_apb_lin_initiator.sv
// Directed bench for apb_lin_initiator: expected responses are queued at issue and checked by a monitor.
module tb_apb_lin_initiator;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_lin_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_lin_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(clk),
    .preset_i(rst_n),
    .bus(bus.master)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completer model: answers on ACCESS cycle number cfg_ws (0-based); cfg_ws < 0 never answers.
  int          cfg_ws = 0;
  bit          cfg_err = 1'b0;
  logic [31:0] cfg_rdata = '0;
  int          acc = 0;
  initial begin
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    bus.prdata_i  = '0;
    forever begin
      @(negedge clk);
      if (bus.psel_o === 1'b1 && bus.penable_o === 1'b1) begin
        bus.pready_i  = (cfg_ws >= 0) && (acc == cfg_ws);
        bus.pslverr_i = bus.pready_i ? cfg_err : 1'b0;
        bus.prdata_i  = bus.pready_i ? cfg_rdata : 32'h0;
        acc++;
      end else begin
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = '0;
        acc = 0;
      end
    end
  end

  // Monitor: bus activity counters and response scoreboard.
  int          psel_tot = 0, pen_tot = 0, unstable_tot = 0, rdwd_tot = 0;
  int          valid_tot = 0, rsp_done = 0, rsp_first_cyc = 0;
  logic [11:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_write;
  logic        prev_valid = 1'b0;
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.psel_o === 1'b1) begin
        psel_tot++;
        if (bus.penable_o !== 1'b1) begin
          s_addr  = bus.paddr_o;
          s_wdata = bus.pwdata_o;
          s_write = bus.pwrite_o;
        end else begin
          pen_tot++;
          if (bus.paddr_o !== s_addr || bus.pwdata_o !== s_wdata || bus.pwrite_o !== s_write)
            unstable_tot++;
        end
        if (bus.pwrite_o === 1'b0 && bus.pwdata_o !== 32'h0) rdwd_tot++;
      end
      if (bus.rsp_valid_o === 1'b1) begin
        valid_tot++;
        if (!prev_valid) rsp_first_cyc = cyc;
        if (bus.rsp_ready_i === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
            chk("rsp_err", bus.rsp_err_o, e.err);
            chk("rsp_timeout", bus.rsp_timeout_o, e.to);
          end
          rsp_done++;
        end
      end
      prev_valid = (bus.rsp_valid_o === 1'b1);
    end
  end

  task automatic run(input string tag, input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                     input int ws, input bit serr, input logic [31:0] prd,
                     input logic [31:0] e_rd, input bit e_err, input bit e_to,
                     input int e_psel, input int e_lat, input int hold);
    int p0, n0, u0, r0, d0, acc_c, k;
    rsp_t e;
    @(posedge clk); #1;
    cfg_ws = ws; cfg_err = serr; cfg_rdata = prd;
    p0 = psel_tot; n0 = pen_tot; u0 = unstable_tot; r0 = rdwd_tot; d0 = rsp_done;
    e.rdata = e_rd; e.err = e_err; e.to = e_to;
    exp_q.push_back(e);
    bus.rsp_ready_i = (hold == 0);
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = wr; bus.cmd_addr_i = addr; bus.cmd_wdata_i = wd;
    k = 0;
    while (bus.cmd_ready_o !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk({tag, "_accept"}, bus.cmd_ready_o, 1);
    acc_c = cyc;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = 12'hFFC; bus.cmd_wdata_i = 32'h0; bus.cmd_write_i = ~wr;
    if (hold > 0) begin
      k = 0;
      do begin @(negedge clk); k++; end while (bus.rsp_valid_o !== 1'b1 && k < 100);
      for (int h = 0; h < hold; h++) begin
        if (h > 0) @(negedge clk);
        chk({tag, "_hold_valid"}, bus.rsp_valid_o, 1);
        chk({tag, "_hold_rdata"}, bus.rsp_rdata_o, e_rd);
        chk({tag, "_hold_err"}, bus.rsp_err_o, e_err);
        chk({tag, "_hold_to"}, bus.rsp_timeout_o, e_to);
        chk({tag, "_hold_cmd_ready"}, bus.cmd_ready_o, 0);
      end
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b1;
    end
    k = 0;
    while (rsp_done == d0 && k < 100) begin @(posedge clk); #1; k++; end
    chk({tag, "_rsp_seen"}, rsp_done - d0, 1);
    chk({tag, "_idle_after"}, bus.cmd_ready_o, 1);
    chk({tag, "_latency"}, rsp_first_cyc - acc_c, e_lat);
    chk({tag, "_psel_cycles"}, psel_tot - p0, e_psel);
    chk({tag, "_penable_cycles"}, pen_tot - n0, (e_psel > 0) ? e_psel - 1 : 0);
    if (e_psel > 0) begin
      chk({tag, "_bus_stable"}, unstable_tot - u0, 0);
      chk({tag, "_paddr"}, s_addr, addr);
      chk({tag, "_pwrite"}, s_write, wr);
      chk({tag, "_pwdata"}, s_wdata, wr ? wd : 32'h0);
      if (!wr) chk({tag, "_rd_pwdata_zero"}, rdwd_tot - r0, 0);
    end
  endtask

  initial begin
    int k, v0;
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
    bus.cmd_wdata_i = '0; bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready_o, 0);
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_penable", bus.penable_o, 0);
    chk("rst_pwrite", bus.pwrite_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    chk("rst_pwdata", bus.pwdata_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("rst_rsp_err", bus.rsp_err_o, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", bus.cmd_ready_o, 1);

    //   tag       wr  addr     wdata         ws  serr prdata        exp_rd        err to  psel lat hold
    run("wr0",     1, 12'h010, 32'hDEADBEEF,  0, 0, 32'h11111111, 32'h00000000, 0, 0,  2,  3, 0);
    run("rd_ws3",  0, 12'h020, 32'hFFFFFFFF,  3, 0, 32'h12345678, 32'h12345678, 0, 0,  5,  6, 0);
    run("rd_serr", 0, 12'h024, 32'h0,         0, 1, 32'hCAFE0001, 32'hCAFE0001, 1, 0,  2,  3, 0);
    run("rd_tmo",  0, 12'h028, 32'h0,        -1, 0, 32'hAAAA5555, 32'h00000000, 1, 1, 17, 18, 0);
    run("rd_ws15", 0, 12'h02C, 32'h0,        15, 0, 32'h0BADF00D, 32'h0BADF00D, 0, 0, 17, 18, 0);
    run("wr_tmo",  1, 12'h030, 32'h5A5A5A5A, -1, 0, 32'h77777777, 32'h00000000, 1, 1, 17, 18, 0);
    run("mis",     1, 12'h013, 32'hFFFFFFFF,  0, 0, 32'h0,        32'h00000000, 1, 0,  0,  1, 0);
    run("rd_hold", 0, 12'h040, 32'h0,         0, 0, 32'h55AA55AA, 32'h55AA55AA, 0, 0,  2,  3, 5);

    // Reset in the middle of a stalled ACCESS phase.
    @(posedge clk); #1;
    cfg_ws = -1;
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 12'h080;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (bus.penable_o !== 1'b1 && k < 20);
    chk("arst_in_access", bus.penable_o, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    v0 = valid_tot;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_psel", bus.psel_o, 0);
    chk("arst_penable", bus.penable_o, 0);
    chk("arst_rsp_valid", bus.rsp_valid_o, 0);
    chk("arst_cmd_ready", bus.cmd_ready_o, 1);
    repeat (5) @(negedge clk);
    chk("arst_no_rsp", valid_tot - v0, 0);
    chk("arst_q_empty", exp_q.size(), 0);

    run("wr_after", 1, 12'h100, 32'h0F0F0F0F, 1, 0, 32'h0, 32'h00000000, 0, 0, 3, 4, 0);
    repeat (3) @(posedge clk);
    chk("end_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
